// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multi-cycle RV32I control FSM.
// Owns PC/IR and sequences fetch/decode/exec/mem/wb over req/ack memories.
module multicycle_sequencer #(
    parameter logic [31:0] PC_RESET    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        write_R,
    output logic        write_M,
    output logic [2:0]  state,
    output logic        fault,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [31:0] ECALL    = 32'h0000_0073;

    localparam int CW = $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

    state_t        st;
    logic [31:0]   ir;
    logic [31:0]   tgt_q;
    logic [CW-1:0] wait_cnt;

    logic [6:0]  opc;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jump;
    logic        is_alu;
    logic [31:0] pc_plus4;
    logic [31:0] br_pc;

    assign opc       = ir[6:0];
    assign is_load   = (opc == OP_LOAD);
    assign is_store  = (opc == OP_STORE);
    assign is_branch = (opc == OP_BRANCH);
    assign is_jump   = (opc == OP_JAL) || (opc == OP_JALR);
    assign is_alu    = (opc == OP_OP) || (opc == OP_IMM) ||
                       (opc == OP_LUI) || (opc == OP_AUIPC);
    assign pc_plus4  = pc + 32'd4;
    assign br_pc     = branch_taken ? branch_target : pc_plus4;

    always_ff @(posedge clk) begin
        if (!reset) begin
            st       <= S_FETCH;
            pc       <= PC_RESET;
            ir       <= '0;
            retired  <= '0;
            wait_cnt <= '0;
            tgt_q    <= '0;
        end else begin
            case (st)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir       <= imem_rdata;
                        wait_cnt <= '0;
                        st       <= S_DECODE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= '0;
                        st       <= S_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (ir == ECALL)
                        st <= S_HALT;
                    else if (is_load || is_store || is_branch ||
                             is_jump || is_alu)
                        st <= S_EXEC;
                    else
                        st <= S_FAULT;
                end
                S_EXEC: begin
                    wait_cnt <= '0;
                    if (is_load || is_store) begin
                        st <= S_MEM;
                    end else if (is_branch) begin
                        // A misaligned target faults and leaves pc alone
                        if (br_pc[1:0] != 2'b00) begin
                            st <= S_FAULT;
                        end else begin
                            pc      <= br_pc;
                            retired <= retired + 32'd1;
                            st      <= S_FETCH;
                        end
                    end else if (is_jump) begin
                        tgt_q <= branch_target;
                        if (branch_target[1:0] != 2'b00)
                            st <= S_FAULT;
                        else
                            st <= S_WB;
                    end else begin
                        st <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        wait_cnt <= '0;
                        if (is_store) begin
                            pc      <= pc_plus4;
                            retired <= retired + 32'd1;
                            st      <= S_FETCH;
                        end else begin
                            st <= S_WB;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= '0;
                        st       <= S_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WB: begin
                    pc       <= is_jump ? tgt_q : pc_plus4;
                    retired  <= retired + 32'd1;
                    wait_cnt <= '0;
                    st       <= S_FETCH;
                end
                S_HALT:  st <= S_HALT;
                S_FAULT: st <= S_FAULT;
                default: st <= S_FAULT;
            endcase
        end
    end

    // Requests drop immediately while reset is held
    assign imem_req    = reset && (st == S_FETCH);
    assign dmem_req    = reset && (st == S_MEM);
    assign dmem_we     = dmem_req && is_store;
    assign write_M     = dmem_req && dmem_we;
    assign write_R     = reset && (st == S_WB) && (ir[11:7] != 5'd0);
    assign imem_addr   = pc;
    assign instruction = ir;
    assign state       = st;
    assign fault       = (st == S_FAULT);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed and random instruction streams
// checked against a per-instruction reference model.
module tb_multicycle_sequencer;

    localparam int TMO = 16;
    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_HALT  = 3'd5;
    localparam logic [2:0] S_FAULT = 3'd6;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        write_R;
    logic        write_M;
    logic [2:0]  state;
    logic        fault;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_pc;
    logic [31:0] m_ret;

    multicycle_sequencer dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .instruction(instruction), .pc(pc),
        .write_R(write_R), .write_M(write_M),
        .state(state), .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = $urandom;
        dmem_ack   = 1'b1;
        #1;
        chk("req_in_reset", {31'd0, imem_req}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_req", {30'd0, imem_req, dmem_req}, 32'd0);
        chk("rst_ret", retired, 32'd0);
        chk("rst_ir", instruction, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        reset    = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        #1;
        chk("req_after_rel", {31'd0, imem_req}, 32'd1);
        m_pc  = 32'h0;
        m_ret = 32'h0;
    endtask

    // Expected outcome of one instruction, derived from the ISA class
    // and the cycle cost of each phase.
    task automatic model(input logic [31:0] ir, input int d, input int e,
                         input logic tk, input logic [31:0] tgt,
                         output int x_cyc, output int x_ireq,
                         output int x_dreq, output int x_wr,
                         output int x_we, output logic [2:0] x_st,
                         output logic [31:0] x_pc,
                         output logic [31:0] x_ret);
        logic [6:0]  op;
        logic [31:0] npc;
        int          rdnz;
        op   = ir[6:0];
        rdnz = (ir[11:7] != 5'd0) ? 1 : 0;
        x_pc = m_pc; x_ret = m_ret;
        x_wr = 0; x_we = 0; x_dreq = 0; x_st = S_FAULT;
        if (d >= TMO) begin
            x_ireq = TMO; x_cyc = TMO;
            return;
        end
        x_ireq = d + 1;
        x_cyc  = d + 2;
        if (ir == 32'h0000_0073) begin
            x_st = S_HALT;
            return;
        end
        case (op)
            7'b0000011, 7'b0100011: begin
                x_cyc += 1;
                if (e >= TMO) begin
                    x_dreq = TMO; x_cyc += TMO;
                    if (op == 7'b0100011) x_we = TMO;
                    return;
                end
                x_dreq = e + 1;
                x_cyc += e + 1;
                if (op == 7'b0100011) begin
                    x_we = e + 1;
                end else begin
                    x_cyc += 1;
                    x_wr = rdnz;
                end
                x_pc = m_pc + 32'd4; x_ret = m_ret + 32'd1; x_st = S_FETCH;
            end
            7'b1100011: begin
                x_cyc += 1;
                npc = tk ? tgt : m_pc + 32'd4;
                if (npc[1:0] == 2'b00) begin
                    x_pc = npc; x_ret = m_ret + 32'd1; x_st = S_FETCH;
                end
            end
            7'b1101111, 7'b1100111: begin
                if (tgt[1:0] != 2'b00) begin
                    x_cyc += 1;
                end else begin
                    x_cyc += 2; x_wr = rdnz;
                    x_pc = tgt; x_ret = m_ret + 32'd1; x_st = S_FETCH;
                end
            end
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: begin
                x_cyc += 2; x_wr = rdnz;
                x_pc = m_pc + 32'd4; x_ret = m_ret + 32'd1; x_st = S_FETCH;
            end
            default: ;
        endcase
    endtask

    task automatic idle(input logic [2:0] st);
        repeat (3) begin
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            dmem_ack   = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            chk("idle_state", {29'd0, state}, {29'd0, st});
            chk("idle_outs", {28'd0, imem_req, dmem_req, write_R, write_M},
                32'd0);
            chk("idle_fault", {31'd0, fault}, {31'd0, st == S_FAULT});
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
    endtask

    // Acts as both memories for one instruction; d/e are ack delays.
    task automatic step(input logic [31:0] ir, input int d, input int e,
                        input logic tk, input logic [31:0] tgt);
        int cyc, ireq, dreq, wr, we, wm;
        int x_cyc, x_ireq, x_dreq, x_wr, x_we;
        logic [2:0]  x_st;
        logic [31:0] x_pc, x_ret;
        logic fetched, done;
        model(ir, d, e, tk, tgt, x_cyc, x_ireq, x_dreq, x_wr, x_we,
              x_st, x_pc, x_ret);
        cyc = 0; ireq = 0; dreq = 0; wr = 0; we = 0; wm = 0;
        fetched = 1'b0; done = 1'b0;
        branch_taken  = tk;
        branch_target = tgt;
        while (!done && cyc < 200) begin
            imem_rdata = $urandom;
            if (imem_req) begin
                imem_ack = (ireq == d);
                if (ireq == d) begin
                    imem_rdata = ir;
                    fetched    = 1'b1;
                end
                ireq++;
            end else begin
                imem_ack = 1'($urandom_range(0, 1));
            end
            if (dmem_req) begin
                dmem_ack = (dreq == e);
                if (dmem_we) we++;
                dreq++;
            end else begin
                dmem_ack = 1'($urandom_range(0, 1));
            end
            if (write_R) wr++;
            if (write_M) wm++;
            cyc++;
            @(posedge clk);
            @(negedge clk);
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            if (state == S_HALT || state == S_FAULT ||
                (state == S_FETCH && fetched))
                done = 1'b1;
        end
        chk("budget", {31'd0, done}, 32'd1);
        chk("state", {29'd0, state}, {29'd0, x_st});
        chk("pc", pc, x_pc);
        chk("addr", imem_addr, x_pc);
        chk("retired", retired, x_ret);
        chk("cycles", cyc, x_cyc);
        chk("imem_req_cyc", ireq, x_ireq);
        chk("dmem_req_cyc", dreq, x_dreq);
        chk("write_R_cyc", wr, x_wr);
        chk("dmem_we_cyc", we, x_we);
        chk("write_M_cyc", wm, x_we);
        chk("fault", {31'd0, fault}, {31'd0, x_st == S_FAULT});
        if (d < TMO) chk("ir", instruction, ir);
        m_pc  = x_pc;
        m_ret = x_ret;
        if (x_st != S_FETCH) begin
            idle(x_st);
            do_reset();
        end
    endtask

    function automatic logic [31:0] rand_ir();
        logic [31:0] r;
        logic [6:0]  o;
        r = $urandom;
        case ($urandom_range(0, 11))
            0:  o = 7'b0000011;
            1:  o = 7'b0100011;
            2:  o = 7'b0110011;
            3:  o = 7'b0010011;
            4:  o = 7'b1100011;
            5:  o = 7'b1101111;
            6:  o = 7'b1100111;
            7:  o = 7'b0110111;
            8:  o = 7'b0010111;
            9:  return 32'h0000_0073;
            10: o = r[6:0];
            default: o = 7'b1100011;
        endcase
        return {r[31:7], o};
    endfunction

    function automatic int rand_dly();
        int k;
        k = $urandom_range(0, 39);
        if (k == 0) return TMO;
        if (k == 1) return TMO - 1;
        return $urandom_range(0, 4);
    endfunction

    initial begin
        logic [31:0] ir, tgt;
        reset = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        imem_rdata = '0; branch_taken = 1'b0; branch_target = '0;

        do_reset();
        step(32'h0050_0093, 3, 0, 1'b0, 32'h0000_0102);
        do_reset();
        step(32'h0020_A023, 0, 2, 1'b1, 32'h0000_0103);
        do_reset();
        step(32'h0000_0063, 0, 0, 1'b1, 32'h0000_0100);
        do_reset();
        step(32'h0000_0063, 0, 0, 1'b0, 32'h0000_0100);
        do_reset();
        step(32'h0000_0063, 0, 0, 1'b1, 32'h0000_0102);
        step(32'h0050_0093, TMO, 0, 1'b0, 32'h0);
        step(32'h0050_0093, TMO - 1, 0, 1'b0, 32'h0);
        step(32'h0000_0073, 1, 0, 1'b0, 32'h0);
        step(32'hFFFF_FFFF, 0, 0, 1'b0, 32'h0);
        step(32'h0000_00EF, 0, 0, 1'b0, 32'h0000_0040);
        step(32'h0000_2083, 2, 4, 1'b0, 32'h0);
        step(32'h0020_A023, 0, TMO, 1'b0, 32'h0);
        step(32'h0000_00EF, 0, 0, 1'b0, 32'hFFFF_FFFC);
        step(32'h0050_0093, 0, 0, 1'b0, 32'h0);

        for (int i = 0; i < 300; i++) begin
            ir  = rand_ir();
            tgt = $urandom;
            if (ir[6:0] == 7'b1101111 || ir[6:0] == 7'b1100111 ||
                ($urandom_range(0, 7) != 0 && ir[6:0] == 7'b1100011))
                tgt[1:0] = 2'b00;
            step(ir, rand_dly(), rand_dly(), 1'($urandom_range(0, 1)), tgt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
